// File: rtl/truth_table_sweeper_if.sv
// Bus between the truth-table sweeper and the combinational block it exercises,
// plus the result signals consumed by LEDs or a bench.
interface truth_table_sweeper_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1
);
  logic             start;
  logic [N_IN-1:0]  stim;
  logic [N_OUT-1:0] dut_f;
  logic             busy;
  logic             done;
  logic             pass;
  logic [N_IN:0]    err_count;
  logic             fail_valid;
  logic [N_IN-1:0]  first_fail_idx;

  // Sweeper side: drives stimulus and results, observes start and the response.
  modport master (
    input  start,
    input  dut_f,
    output stim,
    output busy,
    output done,
    output pass,
    output err_count,
    output fail_valid,
    output first_fail_idx
  );

  // Environment side: the block under test plus whoever launches sweeps.
  modport slave (
    output start,
    output dut_f,
    input  stim,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  fail_valid,
    input  first_fail_idx
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input vector of a combinational
// block, holds each one HOLD_CYCLES clocks and scores the response against EXPECT.
module truth_table_sweeper #(
  parameter int                         N_IN        = 4,
  parameter int                         N_OUT       = 1,
  parameter int                         HOLD_CYCLES = 2,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXPECT      = 16'hA5C3
) (
  input logic                   clk,
  input logic                   rst_n,
  truth_table_sweeper_if.master bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [HW-1:0]   HOLD_RELOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0]   HOLD_ZERO   = HW'(0);
  localparam logic [HW-1:0]   HOLD_ONE    = HW'(1);
  localparam logic [N_IN-1:0] STIM_ZERO   = N_IN'(0);
  localparam logic [N_IN-1:0] STIM_ONE    = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ZERO    = (N_IN+1)'(0);
  localparam logic [N_IN:0]   ERR_ONE     = (N_IN+1)'(1);

  // Expected response for one input vector, sliced out of the packed table.
  function automatic logic [N_OUT-1:0] expect_at(input logic [N_IN-1:0] idx);
    expect_at = EXPECT[int'(idx)*N_OUT +: N_OUT];
  endfunction

  logic [1:0]      r_state;
  logic [N_IN-1:0] r_stim;
  logic [HW-1:0]   r_hold;
  logic            r_busy;
  logic            r_done;
  logic [N_IN:0]   r_err;
  logic            r_fail_valid;
  logic [N_IN-1:0] r_first;

  logic [1:0]      w_state_nxt;
  logic [N_IN-1:0] w_stim_nxt;
  logic [HW-1:0]   w_hold_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic [N_IN:0]   w_err_nxt;
  logic            w_fail_valid_nxt;
  logic [N_IN-1:0] w_first_nxt;

  logic w_sample;
  logic w_mismatch;
  logic w_last;

  assign w_sample   = (r_hold == HOLD_ZERO);
  assign w_mismatch = w_sample && (bus.dut_f != expect_at(r_stim));
  assign w_last     = &r_stim;

  // Next-state logic for the sweep FSM and the result accumulators.
  always_comb begin
    w_state_nxt      = r_state;
    w_stim_nxt       = r_stim;
    w_hold_nxt       = r_hold;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;
    w_err_nxt        = r_err;
    w_fail_valid_nxt = r_fail_valid;
    w_first_nxt      = r_first;

    case (r_state)
      S_IDLE, S_DONE: begin
        // A restart from DONE discards the previous results entirely.
        if (bus.start) begin
          w_state_nxt      = S_APPLY;
          w_stim_nxt       = STIM_ZERO;
          w_hold_nxt       = HOLD_RELOAD;
          w_busy_nxt       = 1'b1;
          w_done_nxt       = 1'b0;
          w_err_nxt        = ERR_ZERO;
          w_fail_valid_nxt = 1'b0;
          w_first_nxt      = STIM_ZERO;
        end else begin
          w_state_nxt = r_state;
        end
      end

      S_APPLY: begin
        if (!w_sample) begin
          w_hold_nxt = r_hold - HOLD_ONE;
        end else begin
          if (w_mismatch) begin
            w_err_nxt = r_err + ERR_ONE;
          end else begin
            w_err_nxt = r_err;
          end

          if (w_mismatch && !r_fail_valid) begin
            w_fail_valid_nxt = 1'b1;
            w_first_nxt      = r_stim;
          end else begin
            w_fail_valid_nxt = r_fail_valid;
          end

          // The all-ones vector ends the sweep; stim parks there rather than wrapping.
          if (w_last) begin
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_stim_nxt = r_stim + STIM_ONE;
            w_hold_nxt = HOLD_RELOAD;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset wipes any partial sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_stim       <= STIM_ZERO;
      r_hold       <= HOLD_ZERO;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= ERR_ZERO;
      r_fail_valid <= 1'b0;
      r_first      <= STIM_ZERO;
    end else begin
      r_state      <= w_state_nxt;
      r_stim       <= w_stim_nxt;
      r_hold       <= w_hold_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_fail_valid <= w_fail_valid_nxt;
      r_first      <= w_first_nxt;
    end
  end

  assign bus.stim           = r_stim;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.err_count      = r_err;
  assign bus.fail_valid     = r_fail_valid;
  assign bus.first_fail_idx = r_first;
  assign bus.pass           = r_done && (r_err == ERR_ZERO);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised scoreboard bench for truth_table_sweeper: a default instance driven
// by a fault-injecting DUT model, plus a small N_IN=2/N_OUT=2/HOLD=1 instance.
module tb_truth_table_sweeper;

  localparam int          N_IN  = 4;
  localparam int          N_OUT = 1;
  localparam int          HOLD  = 2;
  localparam int          NV    = 16;
  localparam logic [15:0] EXP   = 16'hA5C3;
  localparam logic [7:0]  EXP2  = 8'b11_10_01_00;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_tab = EXP;
  logic [15:0] fault_mask = 16'h0000;
  logic [7:0]  mask2 = 8'h00;

  truth_table_sweeper_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();
  truth_table_sweeper_if #(.N_IN(2), .N_OUT(2)) bus2 ();

  // Behavioural block under test: the truth table with chosen vectors corrupted.
  assign bus.dut_f  = exp_tab[bus.stim] ^ fault_mask[bus.stim];
  assign bus2.dut_f = bus2.stim ^ mask2[bus2.stim*2 +: 2];

  truth_table_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .HOLD_CYCLES(HOLD), .EXPECT(EXP)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  truth_table_sweeper #(.N_IN(2), .N_OUT(2), .HOLD_CYCLES(1), .EXPECT(EXP2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  typedef struct {
    int         start_cyc;
    logic [4:0] err;
    logic       fv;
    logic [3:0] first;
    logic       pass;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: checks stim trajectory every cycle of a sweep and final results at done.
  always @(negedge clk) begin
    exp_t e;
    int   off;
    if (rst_n && sb_q.size() > 0) begin
      e   = sb_q[0];
      off = cyc - e.start_cyc;
      if (off >= 0 && off < NV*HOLD) begin
        chk("stim_seq", bus.stim, off / HOLD);
        chk("busy_seq", bus.busy, 1);
        chk("done_early", bus.done, 0);
      end else if (off == NV*HOLD) begin
        chk("done_rise", bus.done, 1);
        chk("busy_end", bus.busy, 0);
        chk("stim_end", bus.stim, NV - 1);
        chk("err_count", bus.err_count, e.err);
        chk("fail_valid", bus.fail_valid, e.fv);
        chk("first_fail_idx", bus.first_fail_idx, e.first);
        chk("pass", bus.pass, e.pass);
        void'(sb_q.pop_front());
      end
    end
  end

  // Reference: result is just the population and lowest index of corrupted vectors.
  task automatic issue_start(input logic [15:0] mask);
    exp_t e;
    int   n;
    int   f;
    bit   found;
    n = 0; f = 0; found = 1'b0;
    for (int v = 0; v < NV; v++) begin
      if (mask[v]) begin
        n++;
        if (!found) begin
          f = v;
          found = 1'b1;
        end
      end
    end
    e.err   = 5'(n);
    e.fv    = found;
    e.first = 4'(f);
    e.pass  = (n == 0);
    @(negedge clk);
    fault_mask = mask;
    bus.start  = 1'b1;
    e.start_cyc = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sweep_timeout: %0d results still pending after %0d cycles", sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  task automatic wait_stim(input logic [3:0] v, input int budget);
    int n;
    n = 0;
    while (bus.stim != v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_stim", bus.stim, v);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stim"}, bus.stim, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_pass"}, bus.pass, 0);
    chk({tag, "_err"}, bus.err_count, 0);
    chk({tag, "_fv"}, bus.fail_valid, 0);
    chk({tag, "_first"}, bus.first_fail_idx, 0);
  endtask

  task automatic run2(input logic [7:0] m);
    int n;
    int f;
    bit found;
    n = 0; f = 0; found = 1'b0;
    for (int v = 0; v < 4; v++) begin
      if (m[v*2 +: 2] != 2'b00) begin
        n++;
        if (!found) begin
          f = v;
          found = 1'b1;
        end
      end
    end
    @(negedge clk);
    mask2 = m;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("d2_stim", bus2.stim, k);
      chk("d2_done_early", bus2.done, 0);
      @(negedge clk);
    end
    chk("d2_done", bus2.done, 1);
    chk("d2_err", bus2.err_count, n);
    chk("d2_fv", bus2.fail_valid, found);
    if (found) chk("d2_first", bus2.first_fail_idx, f);
    else chk("d2_first", bus2.first_fail_idx, 0);
    chk("d2_pass", bus2.pass, (n == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] m;
    bus.start  = 1'b0;
    bus2.start = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    chk("reset_d2_done", bus2.done, 0);
    chk("reset_d2_stim", bus2.stim, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Good DUT, single flipped vector 5, fully inverted DUT.
    issue_start(16'h0000); wait_idle(100);
    issue_start(16'h0020); wait_idle(100);
    issue_start(16'hFFFF); wait_idle(100);

    // Random fault patterns, dense and sparse.
    for (int i = 0; i < 4; i++) begin
      m = 16'($urandom);
      if (i[0]) m = m & 16'($urandom) & 16'($urandom);
      issue_start(m); wait_idle(100);
    end
    issue_start(16'h8000); wait_idle(100);

    // start while busy is ignored; trajectory and done timing stay anchored.
    issue_start(16'h0000);
    wait_stim(4'd3, 100);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(100);

    // Results hold in DONE, then a restart clears them.
    issue_start(16'h0101); wait_idle(100);
    repeat (3) @(negedge clk);
    chk("hold_done", bus.done, 1);
    chk("hold_err", bus.err_count, 2);
    chk("hold_fv", bus.fail_valid, 1);
    chk("hold_first", bus.first_fail_idx, 0);
    chk("hold_pass", bus.pass, 0);
    issue_start(16'h0000);
    chk("restart_err", bus.err_count, 0);
    chk("restart_fv", bus.fail_valid, 0);
    chk("restart_done", bus.done, 0);
    chk("restart_pass", bus.pass, 0);
    wait_idle(100);

    // Reset mid-sweep at stim=7, then a clean sweep.
    issue_start(16'h0004);
    wait_stim(4'd7, 100);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("post_rst_idle");
    issue_start(16'h0000); wait_idle(100);

    // Small configuration: N_IN=2, N_OUT=2, HOLD=1.
    run2(8'h00);
    run2(8'($urandom) | 8'h04);
    run2(8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Synthesisable, self-checking exhaustive-stimulus engine for combinational lab blocks. Replaces hand-written per-vector testbench sequences.
- On `start`, drives every input combination 0 .. 2^N_IN-1 onto a DUT and holds each vector for HOLD_CYCLES clocks.
- Samples the DUT output on the last hold cycle and compares it against a parametrised truth table.
- Reports mismatch count, first failing index, and pass/fail. Sits between a DUT and board LEDs or a bench.

Parameters:
- N_IN, 4, DUT input width; vectors swept = 2^N_IN (legal 1..8).
- N_OUT, 1, DUT output width (legal 1..4).
- HOLD_CYCLES, 2, clocks each vector is held (legal >=1).
- EXPECT, 16'hA5C3, expected truth table, width N_OUT*2^N_IN. Expected value for vector i is EXPECT[i*N_OUT +: N_OUT].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- stim  output  N_IN  vector driven to the DUT.
- dut_f  input  N_OUT  DUT response.
- busy  output  1  high while sweeping.
- done  output  1  high from sweep completion until the next start is accepted.
- pass  output  1  done && err_count==0.
- err_count  output  N_IN+1  number of mismatching vectors; cannot overflow.
- fail_valid  output  1  at least one mismatch recorded.
- first_fail_idx  output  N_IN  index of the first mismatching vector.

Behaviour:
- Reset (async assert, any state): state=IDLE. stim, busy, done, pass, err_count, fail_valid, first_fail_idx and hold_cnt all 0.
- FSM states: IDLE, APPLY, DONE.
- IDLE, start=1: next cycle stim=0, hold_cnt=HOLD_CYCLES-1, err_count=0, fail_valid=0, first_fail_idx=0, busy=1, state=APPLY.
- APPLY, hold_cnt!=0: hold_cnt decrements; stim is unchanged.
- APPLY, hold_cnt==0 (sample cycle): dut_f is compared with EXPECT[stim].
  - On mismatch: err_count increments on the same edge.
  - If fail_valid was 0: fail_valid=1 and first_fail_idx=stim.
- End of a sample cycle:
  - stim != all-ones: stim increments and hold_cnt reloads to HOLD_CYCLES-1.
  - stim == all-ones: state=DONE, busy=0, done=1. stim holds at all-ones (no wrap).
- Each vector is held exactly HOLD_CYCLES clocks. done rises exactly 2^N_IN*HOLD_CYCLES clocks after the edge that accepted start.
- The mismatch on the final vector is included in err_count/pass at the same edge done rises.
- DONE: all results hold. start=1 restarts exactly as from IDLE (clears results, stim=0, done=0).
- start while busy: ignored, no effect.
- pass is combinational from done and err_count. It is 0 whenever done=0.
- dut_f is sampled only on sample cycles; its value on other cycles is don't-care, which covers DUT settling time.
- HOLD_CYCLES=1: every APPLY cycle is a sample cycle and stim advances every clock.
- Reset mid-sweep: immediate return to the reset values above. No partial results are retained.
- Single clock domain. start and dut_f are synchronous to clk.

Test Plan:
- Defaults, behavioural DUT model equal to EXPECT, start pulse at t0:
  - stim steps 0..15, two clocks each.
  - done=1 at edge 32 after start; pass=1, err_count=0, fail_valid=0.
- DUT model with bit flipped only at vector 5:
  - err_count=1, fail_valid=1, first_fail_idx=5, pass=0.
- DUT model outputting ~EXPECT for all vectors:
  - err_count=16 (5'b10000), first_fail_idx=0, pass=0.
- rst_n pulsed low while stim=7:
  - All outputs 0 asynchronously, state IDLE.
  - Next start sweeps from 0; with a good DUT, pass=1.
- start asserted at stim=3 mid-sweep: no restart, done at edge 32 as normal.
- start in DONE after a failing run: results clear next cycle, new sweep with a good DUT ends pass=1.
- N_IN=2, N_OUT=2, HOLD_CYCLES=1, EXPECT=8'b11_10_01_00, DUT f=stim:
  - done at edge 4, pass=1.
